open_loop_angle_sequencer: RTL and testbench
============================================

# open_loop_angle_sequencer

Sequences the open-loop FOC voltage path once per PWM period. On each PWM update event it ramps the electrical speed toward a target and advances the electrical angle with wrap in [-PI, PI). It issues that angle to `sin_cos`, waits for the result, scales it by a voltage amplitude, and hands a single `{alpha, beta}` beat to `SVPWM`. It sits between `PWM_Controller.events_out[0]`, `sin_cos` and `SVPWM`, and replaces the free-running angle counter in the top level.

## Interface
- `WAIT_TIMEOUT`, default 64: maximum cycles spent waiting for `sin_cos_tvalid` before a timeout fault.
- `SPEED_MAX`, default 16384: magnitude clamp on the speed target, Q3.15 rad per PWM period.
- `clk` in 1: system clock.
- `rstn` in 1: asynchronous, active-low reset.
- `enable` in 1: level; when high, events start transactions.
- `event_tick` in 1: one-cycle PWM update event pulse.
- `speed_target` in 18: signed Q3.15, angle increment per event.
- `ramp_step` in 18: unsigned, maximum speed change per event.
- `amplitude` in 16: unsigned Q0.15; values above 32767 are treated as 32767.
- `theta_tdata` out 18: signed Q3.15 angle to `sin_cos`.
- `theta_tvalid` out 1: one-cycle strobe to `sin_cos`.
- `sin_cos_tdata` in 34: sin in [33:17], cos in [16:0], each signed Q1.15 (17 bit).
- `sin_cos_tvalid` in 1: result strobe from `sin_cos`.
- `alpha_beat_tdata` out 32: alpha in [31:16] (from sin), beta in [15:0] (from cos), each signed Q0.15.
- `alpha_beat_tvalid` out 1: one-cycle strobe to `SVPWM`.
- `theta_now` out 18: current angle.
- `speed_now` out 18: current ramped speed.
- `busy` out 1: state is not IDLE.
- `overrun` out 1: sticky; set when an event is dropped.
- `timeout` out 1: sticky; set when `sin_cos` failed to respond.
- `flags_clr` in 1: clears `overrun` and `timeout`.

## Operation
- **Constants:** PI = 102943, TWO_PI = 205886 (exactly 2·PI).
- **Reset values:**
  - `theta_now`, `theta_tdata` = -PI.
  - `speed_now` = 0.
  - All data outputs other than the angle = 0.
  - All strobes and flags = 0.
  - State = IDLE.
- **States:** IDLE → ISSUE → WAIT → SCALE → OUT → IDLE.
- **IDLE:**
  - `event_tick` && `enable` → ISSUE.
  - On entry to ISSUE, update the speed:
    - clamp `speed_target` to ±`SPEED_MAX`, giving `tgt`;
    - if `speed_now` < `tgt`: `speed_now` = min(`speed_now` + `ramp_step`, `tgt`);
    - if `speed_now` > `tgt`: `speed_now` = max(`speed_now` − `ramp_step`, `tgt`).
  - Then update the angle with the new speed, computed in 19 bits:
    - t = `theta_now` + `speed_now`;
    - if t ≥ PI: t −= TWO_PI;
    - else if t < −PI: t += TWO_PI;
    - `theta_now` = t.
- **ISSUE:** drive `theta_tdata` = `theta_now`, pulse `theta_tvalid` for one cycle, then go to WAIT.
- **WAIT:**
  - On `sin_cos_tvalid`, capture sin and cos and go to SCALE.
  - After `WAIT_TIMEOUT` cycles without it: set `timeout`, go to IDLE, emit no output beat.
- **SCALE:** for each of sin and cos:
  - p = x · amp (33-bit signed);
  - r = p >>> 15 (arithmetic shift);
  - saturate r to [−32768, 32767].
- **OUT:** drive `alpha_beat_tdata`, pulse `alpha_beat_tvalid` for one cycle, return to IDLE.
- **Event while not IDLE:** set `overrun` and drop the event. Speed and angle are not updated.
- **`enable` low:**
  - Events are ignored and `overrun` is not set.
  - `speed_now` is forced to 0 each cycle; `theta_now` holds.
  - An in-flight transaction completes normally.
- **`sin_cos_tvalid` outside WAIT:** ignored.
- **`flags_clr` on the same cycle a flag sets:** set wins.
- **`amplitude` and `speed_target`:** sampled on the cycle the event is accepted.

## Timing
- Event accepted at cycle 0.
- `theta_tvalid` is high at cycle 1, carrying the updated angle.
- `sin_cos_tvalid` arrives at cycle k. `alpha_beat_tvalid` is high at cycle k+2, with data valid on the same cycle.
- `busy` is high from cycle 1 through the OUT cycle inclusive.
- A new event is accepted on the first cycle after OUT.
- `theta_now` and `speed_now` change only on the cycle an event is accepted, and are visible from cycle 1.
- Asynchronous reset mid-transaction returns to the reset values immediately. A late `sin_cos_tvalid` after reset is ignored.

## Structure
- Shared package `foc_pkg` holds:
  - `FRAC_BITS` = 15;
  - PI, TWO_PI and PI_BY_2 in Q3.15;
  - `THETA_W` = 18;
  - the sequencer state enum.
- Sub-module `q15_sat_mul`: signed 17×16 multiply, arithmetic shift by 15, saturation to 16 bits. Instantiated twice (sin and cos) in the SCALE stage.

## Test plan
- **Ramp:** reset; `speed_target` = 1000, `ramp_step` = 250, `enable` = 1; 5 events, each answered by `sin_cos`. Expected:
  - `speed_now` = 250, 500, 750, 1000, 1000;
  - `theta_tdata` = −102693, −102193, −101443, −100443, −99443.
- **Wrap:**
  - With `theta_now` = 102500 and speed 1000, one event → `theta_tdata` = −102386.
  - With `theta_now` = −102900 and speed −1000, one event → 101986.
- **Scaling and saturation:**
  - sin = 16384, cos = −16384, amplitude = 16384 → `alpha_beat_tdata` = {8192, −8192}.
  - sin = 32800, amplitude = 32767 → alpha = 32767 (saturated).
  - Latency: `sin_cos_tvalid` to `alpha_beat_tvalid` = 2 cycles.
- **Overrun:**
  - An event during WAIT sets `overrun`, and `theta_now` is unchanged.
  - `flags_clr` together with a second dropped event leaves `overrun` = 1.
- **Timeout:** never assert `sin_cos_tvalid`. Expected:
  - `timeout` = 1 exactly 64 cycles after WAIT entry;
  - no `alpha_beat_tvalid`;
  - `busy` = 0 on the next cycle.
- **Disable and reset:**
  - `enable` = 0 mid-transaction: the transaction completes, `speed_now` becomes 0, and later events produce no `theta_tvalid`.
  - `rstn` low during WAIT: `theta_now` = −102943 immediately.

Source files
------------

// File: rtl/foc_pkg.sv
// Shared fixed-point constants and sequencer state encoding for the open-loop FOC path.
package foc_pkg;

    localparam int unsigned FRAC_BITS = 15;
    localparam int unsigned THETA_W   = 18;

    // Angles in Q3.15 radians
    localparam int PI      = 102943;
    localparam int TWO_PI  = 205886;
    localparam int PI_BY_2 = 51471;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_SCALE,
        ST_OUT
    } seq_state_e;

endpackage

// File: rtl/q15_sat_mul.sv
// Signed Q1.15 x Q0.15 multiply, arithmetic renormalise by 15, saturate to 16 bits.
module q15_sat_mul
    import foc_pkg::*;
(
    input  logic signed [16:0] x,
    input  logic signed [15:0] amp,
    output logic signed [15:0] y_c
);

    logic signed [32:0] prod_c;
    logic signed [32:0] shr_c;

    always_comb begin
        prod_c = 33'(x) * 33'(amp);
        shr_c  = prod_c >>> FRAC_BITS;
        if (shr_c > 33'sd32767) begin
            y_c = 16'sh7FFF;
        end else if (shr_c < -33'sd32768) begin
            y_c = 16'sh8000;
        end else begin
            y_c = 16'(shr_c);
        end
    end

endmodule

// File: rtl/open_loop_angle_sequencer.sv
// Per-PWM-event speed ramp, angle advance with wrap, sin/cos request and amplitude
// scaling into a single alpha/beta beat for SVPWM.
module open_loop_angle_sequencer
    import foc_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 64,
    parameter int unsigned SPEED_MAX    = 16384
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      enable,
    input  logic                      event_tick,
    input  logic signed [THETA_W-1:0] speed_target,
    input  logic        [THETA_W-1:0] ramp_step,
    input  logic        [15:0]        amplitude,
    output logic signed [THETA_W-1:0] theta_tdata,
    output logic                      theta_tvalid,
    input  logic        [33:0]        sin_cos_tdata,
    input  logic                      sin_cos_tvalid,
    output logic        [31:0]        alpha_beat_tdata,
    output logic                      alpha_beat_tvalid,
    output logic signed [THETA_W-1:0] theta_now,
    output logic signed [THETA_W-1:0] speed_now,
    output logic                      busy,
    output logic                      overrun,
    output logic                      timeout,
    input  logic                      flags_clr
);

    localparam int unsigned ACC_W = THETA_W + 2;
    localparam int unsigned THW1  = THETA_W + 1;
    localparam int unsigned CNT_W = $clog2(WAIT_TIMEOUT + 1);

    localparam logic signed [ACC_W-1:0]   SMAX      = ACC_W'(SPEED_MAX);
    localparam logic signed [ACC_W-1:0]   SMIN      = -SMAX;
    localparam logic signed [THW1-1:0]    PI_W      = THW1'(PI);
    localparam logic signed [THW1-1:0]    TWO_PI_W  = THW1'(TWO_PI);
    localparam logic signed [THETA_W-1:0] THETA_RST = THETA_W'(-PI);

    seq_state_e                state;
    logic        [CNT_W-1:0]   wait_cnt;
    logic signed [16:0]        sin_q;
    logic signed [16:0]        cos_q;
    logic        [15:0]        amp_q;

    logic signed [ACC_W-1:0]   tgt_c;
    logic signed [ACC_W-1:0]   spd_cur_c;
    logic signed [ACC_W-1:0]   spd_up_c;
    logic signed [ACC_W-1:0]   spd_dn_c;
    logic signed [ACC_W-1:0]   spd_next_c;
    logic signed [THW1-1:0]    theta_sum_c;
    logic signed [THW1-1:0]    theta_wrap_c;
    logic signed [THETA_W-1:0] theta_next_c;
    logic        [15:0]        amp_sat_c;
    logic signed [15:0]        alpha_c;
    logic signed [15:0]        beta_c;

    // Speed ramp toward the clamped target, then angle advance wrapped into [-PI, PI)
    always_comb begin
        tgt_c = ACC_W'(speed_target);
        if (tgt_c > SMAX) begin
            tgt_c = SMAX;
        end else if (tgt_c < SMIN) begin
            tgt_c = SMIN;
        end
        spd_cur_c = ACC_W'(speed_now);
        spd_up_c  = spd_cur_c + $signed({2'b00, ramp_step});
        spd_dn_c  = spd_cur_c - $signed({2'b00, ramp_step});
        if (spd_cur_c < tgt_c) begin
            spd_next_c = (spd_up_c > tgt_c) ? tgt_c : spd_up_c;
        end else if (spd_cur_c > tgt_c) begin
            spd_next_c = (spd_dn_c < tgt_c) ? tgt_c : spd_dn_c;
        end else begin
            spd_next_c = tgt_c;
        end
        theta_sum_c = THW1'(theta_now) + THW1'(spd_next_c);
        if (theta_sum_c >= PI_W) begin
            theta_wrap_c = theta_sum_c - TWO_PI_W;
        end else if (theta_sum_c < -PI_W) begin
            theta_wrap_c = theta_sum_c + TWO_PI_W;
        end else begin
            theta_wrap_c = theta_sum_c;
        end
        theta_next_c = THETA_W'(theta_wrap_c);
        amp_sat_c    = amplitude[15] ? 16'h7FFF : amplitude;
    end

    q15_sat_mul u_mul_sin (
        .x   (sin_q),
        .amp (amp_q),
        .y_c (alpha_c)
    );

    q15_sat_mul u_mul_cos (
        .x   (cos_q),
        .amp (amp_q),
        .y_c (beta_c)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state             <= ST_IDLE;
            wait_cnt          <= '0;
            sin_q             <= '0;
            cos_q             <= '0;
            amp_q             <= '0;
            theta_now         <= THETA_RST;
            theta_tdata       <= THETA_RST;
            theta_tvalid      <= 1'b0;
            speed_now         <= '0;
            alpha_beat_tdata  <= '0;
            alpha_beat_tvalid <= 1'b0;
            busy              <= 1'b0;
            overrun           <= 1'b0;
            timeout           <= 1'b0;
        end else begin
            theta_tvalid      <= 1'b0;
            alpha_beat_tvalid <= 1'b0;
            if (flags_clr) begin
                overrun <= 1'b0;
                timeout <= 1'b0;
            end
            if (!enable) begin
                speed_now <= '0;
            end
            // Events arriving mid-transaction are dropped and flagged
            if (event_tick && enable && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (event_tick && enable) begin
                        speed_now    <= THETA_W'(spd_next_c);
                        theta_now    <= theta_next_c;
                        theta_tdata  <= theta_next_c;
                        theta_tvalid <= 1'b1;
                        amp_q        <= amp_sat_c;
                        busy         <= 1'b1;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (sin_cos_tvalid) begin
                        sin_q <= $signed(sin_cos_tdata[33:17]);
                        cos_q <= $signed(sin_cos_tdata[16:0]);
                        state <= ST_SCALE;
                    end else if (wait_cnt == CNT_W'(WAIT_TIMEOUT - 1)) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_SCALE: begin
                    alpha_beat_tdata  <= {alpha_c, beta_c};
                    alpha_beat_tvalid <= 1'b1;
                    state             <= ST_OUT;
                end
                ST_OUT: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_open_loop_angle_sequencer.sv
// Scoreboard bench for open_loop_angle_sequencer against an arithmetic reference model.
module tb_open_loop_angle_sequencer;

    localparam int PI_V     = 102943;
    localparam int TWO_PI_V = 205886;
    localparam int SMAX_V   = 16384;

    logic               clk;
    logic               rstn;
    logic               enable;
    logic               event_tick;
    logic signed [17:0] speed_target;
    logic        [17:0] ramp_step;
    logic        [15:0] amplitude;
    logic signed [17:0] theta_tdata;
    logic               theta_tvalid;
    logic        [33:0] sin_cos_tdata;
    logic               sin_cos_tvalid;
    logic        [31:0] alpha_beat_tdata;
    logic               alpha_beat_tvalid;
    logic signed [17:0] theta_now;
    logic signed [17:0] speed_now;
    logic               busy;
    logic               overrun;
    logic               timeout;
    logic               flags_clr;

    open_loop_angle_sequencer dut (
        .clk               (clk),
        .rstn              (rstn),
        .enable            (enable),
        .event_tick        (event_tick),
        .speed_target      (speed_target),
        .ramp_step         (ramp_step),
        .amplitude         (amplitude),
        .theta_tdata       (theta_tdata),
        .theta_tvalid      (theta_tvalid),
        .sin_cos_tdata     (sin_cos_tdata),
        .sin_cos_tvalid    (sin_cos_tvalid),
        .alpha_beat_tdata  (alpha_beat_tdata),
        .alpha_beat_tvalid (alpha_beat_tvalid),
        .theta_now         (theta_now),
        .speed_now         (speed_now),
        .busy              (busy),
        .overrun           (overrun),
        .timeout           (timeout),
        .flags_clr         (flags_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    function automatic void check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct { int v; int c; } th_exp_t;
    typedef struct { int a; int b; int c; } al_exp_t;
    th_exp_t th_q[$];
    al_exp_t al_q[$];

    // Reference model state
    int m_speed = 0;
    int m_theta = -PI_V;
    int cur_amp = 0;

    function automatic void model_event(input int tgt_in, input int step);
        int tgt;
        tgt = (tgt_in > SMAX_V) ? SMAX_V : ((tgt_in < -SMAX_V) ? -SMAX_V : tgt_in);
        if (m_speed < tgt) m_speed = (m_speed + step > tgt) ? tgt : m_speed + step;
        else if (m_speed > tgt) m_speed = (m_speed - step < tgt) ? tgt : m_speed - step;
        m_theta = m_theta + m_speed;
        if (m_theta >= PI_V) m_theta = m_theta - TWO_PI_V;
        else if (m_theta < -PI_V) m_theta = m_theta + TWO_PI_V;
    endfunction

    function automatic int scale(input int x, input int amp);
        longint p;
        int a;
        a = (amp > 32767) ? 32767 : amp;
        p = longint'(x) * longint'(a);
        p = p >>> 15;
        if (p > 32767) p = 32767;
        if (p < -32768) p = -32768;
        return int'(p);
    endfunction

    // Monitor: pops expectations whenever the DUT strobes an output
    always @(negedge clk) begin
        if (rstn && theta_tvalid) begin
            check("theta_beat_expected", int'(th_q.size() > 0), 1);
            if (th_q.size() > 0) begin
                th_exp_t e;
                e = th_q.pop_front();
                check("theta_tdata", int'(theta_tdata), e.v);
                check("theta_cycle", cyc, e.c);
            end
        end
        if (rstn && alpha_beat_tvalid) begin
            check("alpha_beat_expected", int'(al_q.size() > 0), 1);
            if (al_q.size() > 0) begin
                al_exp_t e;
                e = al_q.pop_front();
                check("alpha", int'($signed(alpha_beat_tdata[31:16])), e.a);
                check("beta", int'($signed(alpha_beat_tdata[15:0])), e.b);
                check("alpha_cycle", cyc, e.c);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one event from IDLE; returns one cycle later (ISSUE cycle)
    task automatic start_event(input int tgt, input int step, input int amp);
        speed_target = 18'(tgt);
        ramp_step    = 18'(step);
        amplitude    = 16'(amp);
        event_tick   = 1'b1;
        if (enable) begin
            model_event(tgt, step);
            cur_amp = amp;
            th_q.push_back('{m_theta, cyc + 1});
        end
        tick();
        event_tick = 1'b0;
        if (enable) begin
            check("speed_now", int'(speed_now), m_speed);
            check("theta_now", int'(theta_now), m_theta);
            check("busy_issue", int'(busy), 1);
        end
    endtask

    // Answer from sin_cos now, then run through SCALE/OUT back to IDLE
    task automatic respond(input int s, input int c);
        sin_cos_tdata  = {17'(s), 17'(c)};
        sin_cos_tvalid = 1'b1;
        al_q.push_back('{scale(s, cur_amp), scale(c, cur_amp), cyc + 2});
        tick();
        sin_cos_tvalid = 1'b0;
        tick();
        tick();
    endtask

    task automatic txn(input int tgt, input int step, input int amp,
                       input int s, input int c, input int lat);
        start_event(tgt, step, amp);
        repeat (lat) tick();
        respond(s, c);
    endtask

    function automatic int rnd17();
        return int'($urandom_range(0, 131071)) - 65536;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ramp_theta[5];
        int t0;
        int tcyc;
        int got;
        ramp_theta = '{-102693, -102193, -101443, -100443, -99443};

        rstn = 1'b0; enable = 1'b1; event_tick = 1'b0; speed_target = '0;
        ramp_step = '0; amplitude = '0; sin_cos_tdata = '0; sin_cos_tvalid = 1'b0;
        flags_clr = 1'b0;
        repeat (3) tick();
        check("rst_theta_now", int'(theta_now), -PI_V);
        check("rst_theta_tdata", int'(theta_tdata), -PI_V);
        check("rst_speed", int'(speed_now), 0);
        check("rst_alpha_data", int'(alpha_beat_tdata), 0);
        check("rst_strobes", int'({theta_tvalid, alpha_beat_tvalid}), 0);
        check("rst_flags", int'({busy, overrun, timeout}), 0);
        rstn = 1'b1;
        tick();

        // Ramp
        for (int i = 0; i < 5; i++) begin
            txn(1000, 250, 16384, 1000 * i, -1000 * i, 2 + i);
            check("ramp_theta_table", int'(theta_now), ramp_theta[i]);
            check("ramp_busy_done", int'(busy), 0);
        end

        // Drive theta to 102500, then wrap both directions
        for (int i = 0; i < 12; i++) txn(16384, 262143, 20000, rnd17(), rnd17(), 1);
        txn(5335, 262143, 20000, 100, 200, 1);
        check("pre_wrap_theta", int'(theta_now), 102500);
        txn(1000, 262143, 20000, 100, 200, 1);
        check("wrap_pos_theta", int'(theta_now), -102386);
        txn(-514, 262143, 20000, 100, 200, 1);
        check("pre_wrap_neg_theta", int'(theta_now), -102900);
        txn(-1000, 262143, 20000, 100, 200, 1);
        check("wrap_neg_theta", int'(theta_now), 101986);

        // Scaling, saturation and amplitude clamp
        txn(0, 5000, 16384, 16384, -16384, 3);
        check("scale_half", int'(alpha_beat_tdata), int'({16'sd8192, -16'sd8192}));
        txn(0, 5000, 32767, 32800, -32800, 1);
        txn(0, 5000, 65535, 65535, -65536, 4);
        txn(0, 5000, 40000, -40000, 30000, 2);

        // Overrun during WAIT, flags_clr against a simultaneous drop
        start_event(3000, 700, 12345);
        tick();
        speed_target = 18'(9999);
        event_tick = 1'b1;
        tick();
        event_tick = 1'b0;
        check("overrun_set", int'(overrun), 1);
        check("overrun_theta_hold", int'(theta_now), m_theta);
        check("overrun_speed_hold", int'(speed_now), m_speed);
        event_tick = 1'b1;
        flags_clr = 1'b1;
        tick();
        event_tick = 1'b0;
        flags_clr = 1'b0;
        check("overrun_set_wins", int'(overrun), 1);
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        check("overrun_cleared", int'(overrun), 0);
        respond(-20000, 25000);

        // Timeout: no answer from sin_cos
        t0 = cyc;
        start_event(2000, 500, 30000);
        got = 0;
        tcyc = -1;
        for (int i = 0; i < 200 && got == 0; i++) begin
            @(negedge clk);
            if (timeout) begin
                got = 1;
                tcyc = cyc;
            end
        end
        check("timeout_seen", got, 1);
        check("timeout_cycle", tcyc, t0 + 66);
        @(negedge clk);
        check("timeout_busy_low", int'(busy), 0);
        tick();
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        check("timeout_cleared", int'(timeout), 0);

        // Spurious sin_cos outside WAIT must be ignored
        sin_cos_tdata = {17'(1234), 17'(4321)};
        sin_cos_tvalid = 1'b1;
        tick();
        sin_cos_tvalid = 1'b0;
        tick();

        // Random traffic
        for (int n = 0; n < 24; n++) begin
            txn(int'($urandom_range(0, 40000)) - 20000, int'($urandom_range(0, 3000)),
                int'($urandom_range(0, 65535)), rnd17(), rnd17(),
                int'($urandom_range(1, 12)));
            if ($urandom_range(0, 2) == 0) begin
                sin_cos_tdata = {17'(rnd17()), 17'(rnd17())};
                sin_cos_tvalid = 1'b1;
                tick();
                sin_cos_tvalid = 1'b0;
            end
        end

        // Disable mid-transaction
        start_event(8000, 4000, 25000);
        enable = 1'b0;
        m_speed = 0;
        tick();
        check("disable_speed_zero", int'(speed_now), 0);
        check("disable_theta_hold", int'(theta_now), m_theta);
        tick();
        respond(15000, -15000);
        start_event(8000, 4000, 25000);
        repeat (3) tick();
        check("disable_no_overrun", int'(overrun), 0);
        check("disable_idle", int'(busy), 0);
        check("disable_theta_hold2", int'(theta_now), m_theta);
        enable = 1'b1;
        tick();
        txn(600, 200, 10000, 5000, 6000, 2);

        // Asynchronous reset during WAIT, then a late sin_cos answer
        start_event(900, 300, 20000);
        tick();
        tick();
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_theta", int'(theta_now), -PI_V);
        check("async_rst_speed", int'(speed_now), 0);
        check("async_rst_busy", int'(busy), 0);
        m_theta = -PI_V;
        m_speed = 0;
        tick();
        rstn = 1'b1;
        tick();
        sin_cos_tdata = {17'(7000), 17'(8000)};
        sin_cos_tvalid = 1'b1;
        tick();
        sin_cos_tvalid = 1'b0;
        repeat (3) tick();
        check("late_answer_idle", int'(busy), 0);
        txn(1000, 250, 16384, 3000, 4000, 3);
        check("post_rst_theta", int'(theta_now), -102693);

        repeat (5) tick();
        check("theta_queue_drained", th_q.size(), 0);
        check("alpha_queue_drained", al_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
